// File: rtl/rename_pkg.sv
// Shared types and helpers for the register-rename stage.
package rename_pkg;

  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned NUM_CKPT  = 4;

  localparam int unsigned A_IDX_W = $clog2(ARCH_REGS);
  localparam int unsigned P_IDX_W = $clog2(PHYS_REGS);
  localparam int unsigned CK_W    = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  typedef logic [A_IDX_W-1:0] a_reg_t;
  typedef logic [P_IDX_W-1:0] p_reg_t;
  typedef logic [CK_W-1:0]    ck_tag_t;
  typedef logic [CK_W:0]      ck_cnt_t;
  // Free-list pointer carries one wrap bit so a full list is distinguishable
  // from an empty one; PHYS_REGS is a power of two, so the low bits wrap for free.
  typedef logic [P_IDX_W:0]   fl_ptr_t;

  typedef struct packed {
    logic   valid;
    a_reg_t idx;
  } a_op_t;

  typedef struct packed {
    a_op_t rd;
    a_op_t rs1;
    a_op_t rs2;
    logic  is_branch;
  } dinstr_t;

  typedef struct packed {
    logic   valid;
    p_reg_t idx;
    logic   ready;
  } p_op_t;

  typedef struct packed {
    p_op_t   rd;
    p_op_t   rs1;
    p_op_t   rs2;
    p_reg_t  rd_old;
    ck_tag_t br_tag;
  } rinstr_t;

  typedef p_reg_t [ARCH_REGS-1:0] rat_t;

  typedef struct packed {
    rat_t    rat;
    fl_ptr_t head;
  } ckpt_t;

  // Identity mapping: architectural register i lives in physical register i.
  function automatic rat_t rn_defaults();
    rat_t r;
    for (int unsigned i = 0; i < ARCH_REGS; i++) r[i] = p_reg_t'(i);
    return r;
  endfunction

  function automatic ck_tag_t ck_next(ck_tag_t t);
    return (t == ck_tag_t'(NUM_CKPT - 1)) ? '0 : t + ck_tag_t'(1);
  endfunction

endpackage

// File: rtl/rn_free_list.sv
// Circular free list of physical registers: alloc at head, commit-return at
// tail, head reloadable from a branch checkpoint.
module rn_free_list
  import rename_pkg::*;
(
  input  logic    clk,
  input  logic    rst_ni,
  input  logic    alloc_i,
  output p_reg_t  alloc_idx_o,
  input  logic    free_i,
  input  p_reg_t  free_idx_i,
  input  logic    load_i,
  input  fl_ptr_t load_head_i,
  output fl_ptr_t head_o,
  output fl_ptr_t cnt_o,
  output logic    empty_o
);

  p_reg_t  mem_q [PHYS_REGS];
  fl_ptr_t head_q;
  fl_ptr_t tail_q;

  assign alloc_idx_o = mem_q[head_q[P_IDX_W-1:0]];
  assign head_o      = head_q;
  assign cnt_o       = tail_q - head_q;
  assign empty_o     = (cnt_o == '0);

  // Entry storage: reset holds p(ARCH_REGS)..p(PHYS_REGS-1); commits append at tail.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < PHYS_REGS; i++)
        mem_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? p_reg_t'(ARCH_REGS + i) : '0;
    end else if (free_i) begin
      mem_q[tail_q[P_IDX_W-1:0]] <= free_idx_i;
    end
  end

  // Pointers: a checkpoint load replaces head but never touches tail, so
  // commits landing after the snapshot survive a restore.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(PHYS_REGS - ARCH_REGS);
    end else begin
      if (load_i)       head_q <= load_head_i;
      else if (alloc_i) head_q <= head_q + fl_ptr_t'(1);
      if (free_i)       tail_q <= tail_q + fl_ptr_t'(1);
    end
  end

endmodule

// File: rtl/rename_ckpt.sv
// Single-issue rename stage with a ring of branch checkpoints (RAT + free-list head).
module rename_ckpt
  import rename_pkg::*;
(
  input  logic    clk,
  input  logic    rst_ni,
  input  logic    d_valid_i,
  output logic    d_ready_o,
  input  dinstr_t d_instr_i,
  output logic    r_valid_o,
  output rinstr_t r_instr_o,
  input  logic    wb_valid_i,
  input  p_reg_t  wb_idx_i,
  input  logic    cm_valid_i,
  input  p_reg_t  cm_old_i,
  input  logic    br_valid_i,
  input  ck_tag_t br_tag_i,
  input  logic    br_hit_i
);

  rat_t                 rat_q, rat_next;
  logic [PHYS_REGS-1:0] ready_q;
  ckpt_t                ckpt_q [NUM_CKPT];
  ck_tag_t              ck_rd_q, ck_wr_q;
  ck_cnt_t              ck_cnt_q;
  rinstr_t              rn;
  logic                 r_valid_q;
  rinstr_t              r_instr_q;

  logic    need_alloc, do_alloc, accept, push;
  logic    ck_empty, ck_full, br_pop, br_hit, br_miss;
  p_reg_t  alloc_idx;
  fl_ptr_t fl_head, fl_cnt;
  logic    fl_empty;

  assign need_alloc = d_instr_i.rd.valid && (d_instr_i.rd.idx != '0);
  assign ck_empty   = (ck_cnt_q == '0);
  assign br_pop     = br_valid_i && !ck_empty;
  assign br_hit     = br_pop && br_hit_i;
  assign br_miss    = br_pop && !br_hit_i;
  // A same-cycle hit frees the oldest slot, so a full ring can still take a push.
  assign ck_full    = (ck_cnt_q == ck_cnt_t'(NUM_CKPT)) && !br_hit;

  assign d_ready_o = !(need_alloc && fl_empty) &&
                     !(d_instr_i.is_branch && ck_full) &&
                     !(br_valid_i && !br_hit_i);
  assign accept    = d_valid_i && d_ready_o;
  assign push      = accept && d_instr_i.is_branch;
  assign do_alloc  = accept && need_alloc;

  assign r_valid_o = r_valid_q;
  assign r_instr_o = r_instr_q;

  rn_free_list u_free_list (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .alloc_i     (do_alloc),
    .alloc_idx_o (alloc_idx),
    .free_i      (cm_valid_i && (cm_old_i != '0)),
    .free_idx_i  (cm_old_i),
    .load_i      (br_miss),
    .load_head_i (ckpt_q[ck_rd_q].head),
    .head_o      (fl_head),
    .cnt_o       (fl_cnt),
    .empty_o     (fl_empty)
  );

  // Rename lookup: sources read the pre-rename RAT, with writeback bypass on ready.
  always_comb begin
    rn       = '0;
    rat_next = rat_q;
    if (d_instr_i.rs1.valid) begin
      rn.rs1.valid = 1'b1;
      rn.rs1.idx   = rat_q[d_instr_i.rs1.idx];
      rn.rs1.ready = ready_q[rn.rs1.idx] | (wb_valid_i && (wb_idx_i == rn.rs1.idx));
    end
    if (d_instr_i.rs2.valid) begin
      rn.rs2.valid = 1'b1;
      rn.rs2.idx   = rat_q[d_instr_i.rs2.idx];
      rn.rs2.ready = ready_q[rn.rs2.idx] | (wb_valid_i && (wb_idx_i == rn.rs2.idx));
    end
    if (d_instr_i.rd.valid) begin
      rn.rd.valid = 1'b1;
      if (need_alloc) begin
        rn.rd.idx                   = alloc_idx;
        rn.rd_old                   = rat_q[d_instr_i.rd.idx];
        rat_next[d_instr_i.rd.idx]  = alloc_idx;
      end else begin
        rn.rd.ready = 1'b1;
      end
    end
    if (d_instr_i.is_branch) rn.br_tag = ck_wr_q;
  end

  // RAT: restore from the oldest checkpoint on mispredict, else apply the new mapping.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)       rat_q <= rn_defaults();
    else if (br_miss)  rat_q <= ckpt_q[ck_rd_q].rat;
    else if (do_alloc) rat_q <= rat_next;
  end

  // Ready table: writeback sets, allocation clears (not checkpointed).
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= '1;
    end else begin
      if (wb_valid_i) ready_q[wb_idx_i]  <= 1'b1;
      if (do_alloc)   ready_q[alloc_idx] <= 1'b0;
    end
  end

  // Checkpoint storage: snapshot includes the branch's own rename and allocation.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_CKPT; i++) ckpt_q[i] <= '0;
    end else if (push) begin
      ckpt_q[ck_wr_q] <= {rat_next, fl_head + fl_ptr_t'(need_alloc)};
    end
  end

  // Checkpoint ring pointers; a mispredict flushes every outstanding entry.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ck_rd_q  <= '0;
      ck_wr_q  <= '0;
      ck_cnt_q <= '0;
    end else if (br_miss) begin
      ck_rd_q  <= '0;
      ck_wr_q  <= '0;
      ck_cnt_q <= '0;
    end else begin
      if (push)   ck_wr_q <= ck_next(ck_wr_q);
      if (br_hit) ck_rd_q <= ck_next(ck_rd_q);
      ck_cnt_q <= ck_cnt_q + ck_cnt_t'(push) - ck_cnt_t'(br_hit);
    end
  end

  // Output register: one valid pulse per accepted instruction.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_instr_q <= '0;
    end else begin
      r_valid_q <= accept;
      if (accept) r_instr_q <= rn;
    end
  end

  a_br_not_empty: assert property (@(posedge clk) disable iff (!rst_ni)
    br_valid_i |-> !ck_empty)
    else $error("branch resolved with no outstanding checkpoint");

  a_br_in_order: assert property (@(posedge clk) disable iff (!rst_ni)
    br_pop |-> (br_tag_i == ck_rd_q))
    else $error("branch resolved out of order");

  a_fl_overflow: assert property (@(posedge clk) disable iff (!rst_ni)
    (cm_valid_i && (cm_old_i != '0)) |-> (fl_cnt != fl_ptr_t'(PHYS_REGS)))
    else $error("commit into a full free list");

endmodule
